// File: rtl/rx_prbs_accumulator_pkg.sv
// Shared types and constants for the PRBS despreading accumulator.
package rx_prbs_accumulator_pkg;

    localparam int unsigned ACC_WIDTH           = 25;
    localparam int unsigned RES_WIDTH           = 17;
    localparam int unsigned PRBS_LENGTH_DEFAULT = 255;

    // x^8+x^6+x^5+x^4+1 as a right-shifting Fibonacci register: taps at bits 0,2,3,4
    localparam logic [7:0] LFSR_TAP_MASK = 8'h1D;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDump  = 2'd2
    } acc_state_e;

    function automatic logic [ACC_WIDTH-1:0] acc_abs(input logic signed [ACC_WIDTH-1:0] x);
        logic signed [ACC_WIDTH-1:0] neg;
        neg = -x;
        return x[ACC_WIDTH-1] ? $unsigned(neg) : $unsigned(x);
    endfunction

endpackage

// File: rtl/rx_prbs_lfsr.sv
// 8-bit Fibonacci LFSR chip generator with seed load and advance strobe.
module rx_prbs_lfsr
    import rx_prbs_accumulator_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'h01
) (
    input  logic crx_clk,
    input  logic rrx_rst_n,
    input  logic load,
    input  logic advance,
    output logic chip
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Load wins over advance so the window-closing strobe lands on the seed.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = LFSR_SEED;
        end else if (advance) begin
            lfsr_d = {^(lfsr_q & LFSR_TAP_MASK), lfsr_q[7:1]};
        end
    end

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign chip = lfsr_q[0];

endmodule

// File: rtl/rx_prbs_accumulator.sv
// Correlates two per-chip partial results against a PRBS over a fixed window
// and publishes the window sums with a magnitude-threshold detect flag.
module rx_prbs_accumulator
    import rx_prbs_accumulator_pkg::*;
#(
    parameter int unsigned PRBS_LENGTH = PRBS_LENGTH_DEFAULT,
    parameter logic [7:0]  LFSR_SEED   = 8'h01
) (
    input  logic        crx_clk,
    input  logic        rrx_rst_n,
    input  logic        erx_en,
    input  logic        ibit_ready,
    input  logic [16:0] iresult_0,
    input  logic [16:0] iresult_1,
    input  logic [24:0] ithreshold,
    output logic [24:0] oacc_0,
    output logic [24:0] oacc_1,
    output logic        ovalid,
    output logic        odetect,
    output logic [7:0]  ochip_index
);

    localparam logic [7:0] LAST_IDX = 8'(PRBS_LENGTH - 1);

    acc_state_e state_q, state_d;

    logic signed [ACC_WIDTH-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
    logic signed [ACC_WIDTH-1:0] oacc0_q, oacc0_d, oacc1_q, oacc1_d;
    logic [7:0]                  idx_q, idx_d;

    logic                        chip;
    logic                        consume;
    logic                        last;
    logic                        lfsr_load;
    logic signed [ACC_WIDTH-1:0] ext0, ext1, sum0, sum1;

    rx_prbs_lfsr #(
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .crx_clk   (crx_clk),
        .rrx_rst_n (rrx_rst_n),
        .load      (lfsr_load),
        .advance   (consume),
        .chip      (chip)
    );

    // A DUMP-cycle strobe is chip 0 of the next window, so only IDLE drops strobes.
    assign consume   = ibit_ready && erx_en && (state_q != StIdle);
    assign last      = consume && (idx_q == LAST_IDX);
    assign lfsr_load = !erx_en || last;

    assign ext0 = {{(ACC_WIDTH - RES_WIDTH){iresult_0[RES_WIDTH-1]}}, iresult_0};
    assign ext1 = {{(ACC_WIDTH - RES_WIDTH){iresult_1[RES_WIDTH-1]}}, iresult_1};
    assign sum0 = chip ? (acc0_q + ext0) : (acc0_q - ext0);
    assign sum1 = chip ? (acc1_q + ext1) : (acc1_q - ext1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (erx_en) state_d = StAccum;
            StAccum: if (last)   state_d = StDump;
            StDump:              state_d = StAccum;
            default:             state_d = StIdle;
        endcase
        if (!erx_en) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        acc0_d  = acc0_q;
        acc1_d  = acc1_q;
        oacc0_d = oacc0_q;
        oacc1_d = oacc1_q;
        idx_d   = idx_q;
        if (!erx_en) begin
            acc0_d = '0;
            acc1_d = '0;
            idx_d  = '0;
        end else if (last) begin
            oacc0_d = sum0;
            oacc1_d = sum1;
            acc0_d  = '0;
            acc1_d  = '0;
            idx_d   = '0;
        end else if (consume) begin
            acc0_d = sum0;
            acc1_d = sum1;
            idx_d  = idx_q + 8'd1;
        end
    end

    always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
        if (!rrx_rst_n) begin
            state_q <= StIdle;
            acc0_q  <= '0;
            acc1_q  <= '0;
            oacc0_q <= '0;
            oacc1_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc0_q  <= acc0_d;
            acc1_q  <= acc1_d;
            oacc0_q <= oacc0_d;
            oacc1_q <= oacc1_d;
            idx_q   <= idx_d;
        end
    end

    assign ovalid      = (state_q == StDump) && erx_en;
    assign odetect     = ovalid && ((acc_abs(oacc0_q) >= ithreshold) ||
                                    (acc_abs(oacc1_q) >= ithreshold));
    assign oacc_0      = oacc0_q;
    assign oacc_1      = oacc1_q;
    assign ochip_index = idx_q;

endmodule

// File: tb/tb_rx_prbs_accumulator.sv
// Directed bench: a PRBS_LENGTH=4 instance for window behaviour and a 255-chip instance for range.
module tb_rx_prbs_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic        ibit_ready;
    logic [16:0] r0, r1;
    logic [24:0] thr;

    logic [24:0] oacc_a0, oacc_a1, oacc_b0, oacc_b1;
    logic        ovalid_a, odetect_a, ovalid_b, odetect_b;
    logic [7:0]  idx_a, idx_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rx_prbs_accumulator #(
        .PRBS_LENGTH (4),
        .LFSR_SEED   (8'h01)
    ) dut_a (
        .crx_clk     (clk),
        .rrx_rst_n   (rst_n),
        .erx_en      (en_a),
        .ibit_ready  (ibit_ready),
        .iresult_0   (r0),
        .iresult_1   (r1),
        .ithreshold  (thr),
        .oacc_0      (oacc_a0),
        .oacc_1      (oacc_a1),
        .ovalid      (ovalid_a),
        .odetect     (odetect_a),
        .ochip_index (idx_a)
    );

    rx_prbs_accumulator #(
        .PRBS_LENGTH (255),
        .LFSR_SEED   (8'h01)
    ) dut_b (
        .crx_clk     (clk),
        .rrx_rst_n   (rst_n),
        .erx_en      (en_b),
        .ibit_ready  (ibit_ready),
        .iresult_0   (r0),
        .iresult_1   (r1),
        .ithreshold  (thr),
        .oacc_0      (oacc_b0),
        .oacc_1      (oacc_b1),
        .ovalid      (ovalid_b),
        .odetect     (odetect_b),
        .ochip_index (idx_b)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; presents one strobe across the next rising edge.
    task automatic strobe(input int a, input int b);
        ibit_ready = 1'b1;
        r0 = 17'(a);
        r1 = 17'(b);
        @(negedge clk);
        ibit_ready = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] m;
        int         ones;
        longint     exp_sum;

        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; ibit_ready = 1'b0;
        r0 = '0; r1 = '0; thr = 25'd1000;
        repeat (2) @(negedge clk);
        chk("rst_oacc0", longint'($signed(oacc_a0)), 0);
        chk("rst_ovalid", longint'(ovalid_a), 0);
        chk("rst_odetect", longint'(odetect_a), 0);
        chk("rst_idx", longint'(idx_a), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Strobe on the IDLE->ACCUM cycle is ignored
        en_a = 1'b1;
        strobe(555, 0);
        chk("idle_strobe_idx", longint'(idx_a), 0);

        // Window: chips 1,0,0,0 with +100 each -> -200
        strobe(100, 0);
        chk("w1_idx1", longint'(idx_a), 1);
        strobe(100, 0);
        strobe(100, 0);
        chk("w1_idx3", longint'(idx_a), 3);
        chk("w1_novalid", longint'(ovalid_a), 0);
        strobe(100, 0);
        chk("w1_ovalid", longint'(ovalid_a), 1);
        chk("w1_oacc0", longint'($signed(oacc_a0)), -200);
        chk("w1_oacc1", longint'($signed(oacc_a1)), 0);
        chk("w1_idx0", longint'(idx_a), 0);
        chk("w1_odetect", longint'(odetect_a), 0);

        // Strobe during DUMP becomes chip 0 of the next window
        strobe(0, 7);
        chk("dump_ovalid_drop", longint'(ovalid_a), 0);
        chk("dump_oacc1_held", longint'($signed(oacc_a1)), 0);
        chk("dump_idx", longint'(idx_a), 1);
        strobe(0, 0);
        strobe(0, 0);
        strobe(0, 0);
        chk("w2_ovalid", longint'(ovalid_a), 1);
        chk("w2_oacc1", longint'($signed(oacc_a1)), 7);
        chk("w2_oacc0", longint'($signed(oacc_a0)), 0);

        // Threshold boundary: |-500| >= 500 detects, |-499| and 499 do not
        thr = 25'd500;
        strobe(-500, 499);
        strobe(0, 0);
        strobe(0, 0);
        strobe(0, 0);
        chk("w3_oacc0", longint'($signed(oacc_a0)), -500);
        chk("w3_oacc1", longint'($signed(oacc_a1)), 499);
        chk("w3_odetect", longint'(odetect_a), 1);
        strobe(-499, 499);
        strobe(0, 0);
        strobe(0, 0);
        strobe(0, 0);
        chk("w4_oacc0", longint'($signed(oacc_a0)), -499);
        chk("w4_ovalid", longint'(ovalid_a), 1);
        chk("w4_odetect", longint'(odetect_a), 0);

        // Enable drop mid-window
        @(negedge clk);
        strobe(1000, 0);
        strobe(1, 0);
        chk("drop_pre_idx", longint'(idx_a), 2);
        en_a = 1'b0;
        @(negedge clk);
        chk("drop_idx", longint'(idx_a), 0);
        chk("drop_ovalid", longint'(ovalid_a), 0);
        chk("drop_oacc0_held", longint'($signed(oacc_a0)), -499);
        strobe(77, 0);
        @(negedge clk);
        chk("drop_idx_still", longint'(idx_a), 0);
        en_a = 1'b1;
        @(negedge clk);
        strobe(10, 0);
        strobe(20, 0);
        strobe(30, 0);
        chk("restart_novalid", longint'(ovalid_a), 0);
        chk("restart_idx3", longint'(idx_a), 3);
        strobe(40, 0);
        chk("restart_ovalid", longint'(ovalid_a), 1);
        chk("restart_oacc0", longint'($signed(oacc_a0)), -80);

        // Asynchronous reset between edges clears outputs at once
        strobe(5, 0);
        chk("prereset_idx", longint'(idx_a), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_idx", longint'(idx_a), 0);
        chk("areset_oacc0", longint'($signed(oacc_a0)), 0);
        chk("areset_ovalid", longint'(ovalid_a), 0);
        chk("areset_odetect", longint'(odetect_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        strobe(1, 0);
        strobe(1, 0);
        strobe(1, 0);
        strobe(1, 0);
        chk("postrst_ovalid", longint'(ovalid_a), 1);
        chk("postrst_oacc0", longint'($signed(oacc_a0)), -2);

        // Full 255-chip window at extreme per-chip magnitudes
        en_a = 1'b0;
        en_b = 1'b1;
        thr  = 25'd16000000;
        @(negedge clk);
        m = 8'h01;
        ones = 0;
        exp_sum = 0;
        for (int i = 0; i < 255; i++) begin
            if (m[0]) begin
                ones++;
                exp_sum += 65535;
                strobe(65535, 0);
            end else begin
                exp_sum += 65536;
                strobe(-65536, 0);
            end
            m = {m[0] ^ m[2] ^ m[3] ^ m[4], m[7:1]};
            if (i == 253) begin
                chk("long_idx254", longint'(idx_b), 254);
                chk("long_novalid", longint'(ovalid_b), 0);
            end
        end
        chk("long_ones", longint'(ones), 128);
        chk("long_ovalid", longint'(ovalid_b), 1);
        chk("long_oacc0", longint'($signed(oacc_b0)), exp_sum);
        chk("long_odetect", longint'(odetect_b), 1);
        chk("long_idx0", longint'(idx_b), 0);
        @(negedge clk);
        chk("long_ovalid_1cyc", longint'(ovalid_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
